// File: rtl/memoria_escritura_pkg.sv
// Shared constants and state encoding for the writable 8x32 data memory.
// Imported by the interface, the clear counter and the top.
package memoria_escritura_pkg;

  localparam int DATA_W_DEF = 32;
  localparam int ADDR_W_DEF = 3;
  localparam int LANE_W     = 8;

  typedef enum logic {
    ST_INIT = 1'b0,
    ST_IDLE = 1'b1
  } state_e;

  // The write counter holds at its ceiling instead of wrapping.
  function automatic logic [7:0] sat_inc8(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

endpackage

// File: rtl/memoria_escritura_if.sv
// Write-side valid/ready bus of memoria_escritura: address, data and byte enables.
interface memoria_escritura_if
  import memoria_escritura_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int ADDR_W = ADDR_W_DEF
) ();

  localparam int BE_W = DATA_W / LANE_W;

  logic              wr_valid;
  logic              wr_ready;
  logic [ADDR_W-1:0] wr_addr;
  logic [DATA_W-1:0] wr_data;
  logic [BE_W-1:0]   wr_be;

  modport master (output wr_valid, wr_addr, wr_data, wr_be, input wr_ready);
  modport slave  (input wr_valid, wr_addr, wr_data, wr_be, output wr_ready);

endinterface

// File: rtl/memoria_escritura_init_ctr.sv
// Clear pointer for the INIT sweep; one bit wider than the address so the
// step from the last word to DEPTH is seen as a carry rather than a wrap.
module memoria_escritura_init_ctr
  import memoria_escritura_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF
) (
  input  logic              clk_i,
  input  logic              rst_n_i,
  input  logic              start_i,
  input  logic              en_i,
  output logic [ADDR_W-1:0] ptr_o,
  output logic              last_o
);

  localparam logic [ADDR_W:0] ONE = {{ADDR_W{1'b0}}, 1'b1};

  logic [ADDR_W:0] ptr_q, ptr_d, ptr_inc;

  assign ptr_inc = ptr_q + ONE;
  assign last_o  = ptr_inc[ADDR_W];
  assign ptr_o   = ptr_q[ADDR_W-1:0];

  always_comb begin
    ptr_d = ptr_q;
    if (start_i) begin
      ptr_d = '0;
    end else if (en_i) begin
      ptr_d = last_o ? '0 : ptr_inc;
    end
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      ptr_q <= '0;
    end else begin
      ptr_q <= ptr_d;
    end
  end

endmodule

// File: rtl/memoria_escritura.sv
// Writable DEPTH x DATA_W data memory with byte-enable writes, self-clear after
// reset or on request, and a combinational read port matching the datapath ROMs.
module memoria_escritura
  import memoria_escritura_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int ADDR_W = ADDR_W_DEF
) (
  input  logic                clk_i,
  input  logic                rst_n_i,
  input  logic                clr_i,
  memoria_escritura_if.slave  wr_if,
  input  logic [ADDR_W-1:0]   addr_i,
  output logic [DATA_W-1:0]   dato_o,
  output logic                init_busy_o,
  output logic [7:0]          wr_count_o
);

  localparam int DEPTH = 2 ** ADDR_W;
  localparam int BE_W  = DATA_W / LANE_W;

  state_e            state_q, state_d;
  logic [7:0]        count_q, count_d;
  logic              busy_q;
  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [DATA_W-1:0] merged_w;
  logic [ADDR_W-1:0] clr_ptr;
  logic              clr_last;
  logic              wr_ready_w;
  logic              accept_w;

  assign wr_ready_w     = (state_q == ST_IDLE) && !clr_i;
  assign wr_if.wr_ready = wr_ready_w;
  assign accept_w       = wr_if.wr_valid && wr_ready_w;

  memoria_escritura_init_ctr #(.ADDR_W(ADDR_W)) u_init_ctr (
    .clk_i   (clk_i),
    .rst_n_i (rst_n_i),
    .start_i ((state_q == ST_IDLE) && clr_i),
    .en_i    (state_q == ST_INIT),
    .ptr_o   (clr_ptr),
    .last_o  (clr_last)
  );

  always_comb begin
    state_d = state_q;
    count_d = count_q;
    case (state_q)
      ST_INIT: begin
        if (clr_last) begin
          state_d = ST_IDLE;
        end
      end
      ST_IDLE: begin
        if (clr_i) begin
          state_d = ST_INIT;
          count_d = '0;
        end else if (accept_w) begin
          count_d = sat_inc8(count_q);
        end
      end
      default: state_d = ST_INIT;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q <= ST_INIT;
      count_q <= '0;
      busy_q  <= 1'b1;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
      busy_q  <= (state_d == ST_INIT);
    end
  end

  // Disabled byte lanes keep the currently stored bytes of the target word.
  always_comb begin
    merged_w = mem_q[wr_if.wr_addr];
    for (int k = 0; k < BE_W; k++) begin
      if (wr_if.wr_be[k]) begin
        merged_w[k*LANE_W +: LANE_W] = wr_if.wr_data[k*LANE_W +: LANE_W];
      end
    end
  end

  // Contents are only cleared by the INIT sweep, never by the reset itself.
  always_ff @(posedge clk_i) begin
    if (state_q == ST_INIT) begin
      mem_q[clr_ptr] <= '0;
    end else if (accept_w) begin
      mem_q[wr_if.wr_addr] <= merged_w;
    end
  end

  assign dato_o      = busy_q ? '0 : mem_q[addr_i];
  assign init_busy_o = busy_q;
  assign wr_count_o  = count_q;

endmodule

// File: tb/tb_memoria_escritura.sv
// Scoreboard bench for memoria_escritura: the driver queues per-cycle expectations
// from a word-array model, a negedge monitor pops and compares them.
module tb_memoria_escritura;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        clr = 1'b0;
  logic [2:0]  raddr = '0;
  logic [31:0] dato;
  logic        busy;
  logic [7:0]  cnt;

  memoria_escritura_if #(.DATA_W(32), .ADDR_W(3)) wr_if ();

  memoria_escritura #(.DATA_W(32), .ADDR_W(3)) dut (
    .clk_i       (clk),
    .rst_n_i     (rst_n),
    .clr_i       (clr),
    .wr_if       (wr_if),
    .addr_i      (raddr),
    .dato_o      (dato),
    .init_busy_o (busy),
    .wr_count_o  (cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] dato;
    logic        ready;
    logic        busy;
    logic [7:0]  cnt;
  } exp_t;

  exp_t        exp_q[$];
  int          n_checks = 0;
  int          n_fail = 0;
  string       phase = "start";

  // Reference model: plain word array, countdown of clear cycles, write tally.
  logic [31:0] mdl_mem [8];
  int          init_left;
  int          mcount;

  function automatic void modelReset();
    init_left = 8;
    mcount    = 0;
    for (int i = 0; i < 8; i++) mdl_mem[i] = '0;
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("[TB] FAIL %s (%s) t=%0t: got %h expected %h", name, phase, $time, act, exp);
    end
  endtask

  // Called just after a rising edge; covers exactly one clock cycle.
  task automatic applyStimulus(input bit v, input logic [2:0] wa, input logic [31:0] wd,
                               input logic [3:0] be, input logic [2:0] ra, input bit c);
    exp_t e;
    wr_if.wr_valid = v;
    wr_if.wr_addr  = wa;
    wr_if.wr_data  = wd;
    wr_if.wr_be    = be;
    raddr          = ra;
    clr            = c;
    e.busy  = (init_left > 0);
    e.ready = !e.busy && !c;
    e.dato  = e.busy ? 32'h0 : mdl_mem[ra];
    e.cnt   = mcount[7:0];
    exp_q.push_back(e);
    @(posedge clk);
    if (!rst_n) begin
      modelReset();
    end else if (init_left > 0) begin
      init_left--;
    end else if (c) begin
      modelReset();
    end else if (v) begin
      for (int k = 0; k < 4; k++)
        if (be[k]) mdl_mem[wa][8*k +: 8] = wd[8*k +: 8];
      if (mcount < 255) mcount++;
    end
    #1;
  endtask

  task automatic idleCycle(input logic [2:0] ra);
    applyStimulus(1'b0, 3'd0, 32'h0, 4'h0, ra, 1'b0);
  endtask

  // Asserts reset mid-cycle with a write pending and checks outputs at once.
  task automatic asyncResetCheck(input logic [2:0] ra);
    wr_if.wr_valid = 1'b1;
    wr_if.wr_addr  = ra;
    wr_if.wr_data  = $urandom;
    wr_if.wr_be    = 4'hF;
    raddr          = ra;
    clr            = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    checkOutput("rst_busy", {31'h0, busy}, 32'h1);
    checkOutput("rst_ready", {31'h0, wr_if.wr_ready}, 32'h0);
    checkOutput("rst_dato", dato, 32'h0);
    checkOutput("rst_count", {24'h0, cnt}, 32'h0);
    modelReset();
    @(posedge clk);
    #1;
    idleCycle(3'($urandom_range(0, 7)));
    rst_n = 1'b1;
  endtask

  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      exp_t e;
      e = exp_q.pop_front();
      checkOutput("busy", {31'h0, busy}, {31'h0, e.busy});
      checkOutput("ready", {31'h0, wr_if.wr_ready}, {31'h0, e.ready});
      checkOutput("dato", dato, e.dato);
      checkOutput("count", {24'h0, cnt}, {24'h0, e.cnt});
    end
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    logic [2:0] last_a;
    wr_if.wr_valid = 1'b0;
    wr_if.wr_addr  = '0;
    wr_if.wr_data  = '0;
    wr_if.wr_be    = '0;
    modelReset();
    @(posedge clk);
    #1;

    phase = "reset";
    idleCycle(3'd0);
    idleCycle(3'd3);
    rst_n = 1'b1;

    phase = "init";
    for (int i = 0; i < 8; i++) idleCycle(3'($urandom_range(0, 7)));
    phase = "zero";
    for (int a = 0; a < 8; a++) idleCycle(3'(a));

    phase = "word_wr";
    applyStimulus(1'b1, 3'd1, 32'h0000000A, 4'hF, 3'd1, 1'b0);
    applyStimulus(1'b1, 3'd0, 32'h00000007, 4'hF, 3'd1, 1'b0);
    idleCycle(3'd1);
    idleCycle(3'd0);

    phase = "byte_en";
    applyStimulus(1'b1, 3'd5, 32'hFFFFFFFB, 4'hF, 3'd5, 1'b0);
    applyStimulus(1'b1, 3'd5, 32'h12345678, 4'b0101, 3'd5, 1'b0);
    idleCycle(3'd5);
    applyStimulus(1'b1, 3'd2, 32'hCAFEF00D, 4'h0, 3'd2, 1'b0);
    idleCycle(3'd2);

    phase = "clear";
    applyStimulus(1'b1, 3'd3, 32'h55AA55AA, 4'hF, 3'd3, 1'b1);
    for (int i = 0; i < 8; i++) idleCycle(3'($urandom_range(0, 7)));
    idleCycle(3'd3);
    idleCycle(3'd5);

    phase = "saturate";
    last_a = '0;
    for (int i = 0; i < 300; i++) begin
      last_a = 3'($urandom_range(0, 7));
      applyStimulus(1'b1, last_a, $urandom, 4'($urandom_range(0, 15)),
                    3'($urandom_range(0, 7)), 1'b0);
    end
    idleCycle(last_a);

    phase = "rst_mid_init";
    applyStimulus(1'b0, 3'd0, 32'h0, 4'h0, 3'd0, 1'b1);
    for (int i = 0; i < 4; i++) idleCycle(3'($urandom_range(0, 7)));
    asyncResetCheck(3'd4);
    for (int i = 0; i < 8; i++) idleCycle(3'($urandom_range(0, 7)));
    for (int a = 0; a < 8; a++) idleCycle(3'(a));

    phase = "rst_mid_write";
    applyStimulus(1'b1, 3'd6, 32'hDEADBEEF, 4'hF, 3'd6, 1'b0);
    idleCycle(3'd6);
    asyncResetCheck(3'd6);
    for (int i = 0; i < 8; i++) idleCycle(3'($urandom_range(0, 7)));
    for (int a = 0; a < 8; a++) idleCycle(3'(a));

    phase = "random";
    for (int i = 0; i < 200; i++) begin
      bit c;
      c = (init_left == 0) && ($urandom_range(0, 19) == 0);
      applyStimulus(1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)), $urandom,
                    4'($urandom_range(0, 15)), 3'($urandom_range(0, 7)), c);
    end

    @(negedge clk);
    #1;
    checkOutput("queue_drained", exp_q.size(), 32'h0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
